alu_1bit: RTL and testbench
===========================

ALU_1BIT -- requirements
Module: alu_1bit

Interface
REQ-001 The block SHALL have parameter OUT_REG, default 1, where 1 selects registered outputs (1-cycle latency) and 0 selects purely combinational outputs.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port a, input, 1 bit: operand A.
REQ-005 The block SHALL have port b, input, 1 bit: operand B.
REQ-006 The block SHALL have port cin, input, 1 bit: carry-in for ADD and SUB.
REQ-007 The block SHALL have port op, input, 2 bits: operation select.
REQ-008 The block SHALL have port in_valid, input, 1 bit: qualifies a, b, cin and op in the current cycle.
REQ-009 The block SHALL have port s, output, 1 bit: result bit.
REQ-010 The block SHALL have port cout, output, 1 bit: carry-out.
REQ-011 The block SHALL have port out_valid, output, 1 bit: qualifies s and cout.

Function
REQ-012 The block SHALL compute s from op as follows:
- 00 NOR: s = ~(a | b)
- 01 XOR: s = a ^ b
- 10 ADD: s = a ^ b ^ cin
- 11 SUB: s = a ^ ~b ^ cin
REQ-013 The block SHALL compute cout as follows:
- ADD: cout = majority(a, b, cin)
- SUB: cout = majority(a, ~b, cin)
- NOR and XOR: cout = 0
REQ-014 SUB semantics SHALL be a + ~b + cin, so that an LSB slice with cin=1 performs two's-complement subtraction and chains via cout to the next slice's cin.
REQ-015 With OUT_REG=1, s, cout and out_valid SHALL update on the clk rising edge after inputs are sampled; the latency is exactly 1 cycle.
REQ-016 With OUT_REG=1, s and cout SHALL be loaded only when in_valid=1 and SHALL hold their previous value when in_valid=0.
REQ-017 With OUT_REG=1, out_valid SHALL equal in_valid delayed by one cycle.
REQ-018 With OUT_REG=1, back-to-back valid inputs SHALL be accepted every cycle, with no stall and no backpressure.
REQ-019 With OUT_REG=0, s, cout and out_valid SHALL follow the inputs combinationally (out_valid = in_valid), and clk/rst_n SHALL have no effect.
REQ-020 The result SHALL be determined solely by the current op; no internal state other than the output registers SHALL exist.
REQ-021 X or Z on op SHALL NOT be required to produce a defined output; every defined op value SHALL be fully decoded, with no latch inferred.

Reset
REQ-022 On rst_n=0, with OUT_REG=1, s, cout and out_valid SHALL clear to 0 immediately, independent of clk.
REQ-023 Reset SHALL take effect mid-operation; a valid input sampled on the same edge that reset is asserted SHALL be discarded.
REQ-024 After rst_n deasserts, the first capture SHALL occur on the next clk rising edge with in_valid=1.

Verification
REQ-025 The bench SHALL cover: op=01, a=0, b=0, cin=0, in_valid=1 -> next cycle s=0, cout=0, out_valid=1; then a=1 -> s=1, cout=0.
REQ-026 The bench SHALL cover: op=00 with all four (a,b) combinations -> s = 1,0,0,0 for ab = 00,01,10,11; cout=0 throughout.
REQ-027 The bench SHALL cover: op=10, a=1, b=1, cin=1 -> s=1, cout=1; and a=1, b=0, cin=0 -> s=1, cout=0.
REQ-028 The bench SHALL cover: op=11, a=1, b=1, cin=1 (1-1) -> s=0, cout=1; and a=0, b=1, cin=1 (0-1) -> s=1, cout=0.
REQ-029 The bench SHALL cover: in_valid=1 for one cycle, then 0 for three cycles with changing inputs -> s/cout hold the captured value and out_valid=1 for exactly one cycle.
REQ-030 The bench SHALL cover: assert rst_n=0 between clock edges while s=1 and out_valid=1 -> s, cout and out_valid read 0 before the next edge; after release they stay 0 until a valid input is captured.

Source files
------------

// File: rtl/alu_1bit.sv
// One-bit ALU slice: NOR, XOR, ADD and SUB (a + ~b + cin) with carry-out for ripple chaining.
// OUT_REG selects a one-cycle registered output stage or a purely combinational path.
module alu_1bit #(
    parameter bit OUT_REG = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] op,
    input  logic       in_valid,
    output logic       s,
    output logic       cout,
    output logic       out_valid
);

    typedef enum logic [1:0] {
        OpNor = 2'b00,
        OpXor = 2'b01,
        OpAdd = 2'b10,
        OpSub = 2'b11
    } op_e;

    op_e  op_sel;
    logic s_comb;
    logic cout_comb;

    assign op_sel = op_e'(op);

    always_comb begin
        s_comb    = 1'b0;
        cout_comb = 1'b0;
        unique case (op_sel)
            OpNor: s_comb = ~(a | b);
            OpXor: s_comb = a ^ b;
            OpAdd: begin
                s_comb    = a ^ b ^ cin;
                cout_comb = (a & b) | (a & cin) | (b & cin);
            end
            OpSub: begin
                // Inverted b plus cin=1 on the LSB slice gives two's-complement subtraction.
                s_comb    = a ^ ~b ^ cin;
                cout_comb = (a & ~b) | (a & cin) | (~b & cin);
            end
        endcase
    end

    if (OUT_REG) begin : g_reg
        logic s_q, s_d;
        logic cout_q, cout_d;
        logic valid_q, valid_d;

        always_comb begin
            s_d     = s_q;
            cout_d  = cout_q;
            valid_d = in_valid;
            if (in_valid) begin
                s_d    = s_comb;
                cout_d = cout_comb;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q     <= 1'b0;
                cout_q  <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                s_q     <= s_d;
                cout_q  <= cout_d;
                valid_q <= valid_d;
            end
        end

        assign s         = s_q;
        assign cout      = cout_q;
        assign out_valid = valid_q;
    end else begin : g_comb
        assign s         = s_comb;
        assign cout      = cout_comb;
        assign out_valid = in_valid;
    end

endmodule

// File: tb/tb_alu_1bit.sv
// Self-checking bench for alu_1bit (registered outputs): expected results are queued on
// drive and popped when out_valid rises; holds and reset behaviour are checked directly.
module tb_alu_1bit;

    logic       clk;
    logic       rst_n;
    logic       a;
    logic       b;
    logic       cin;
    logic [1:0] op;
    logic       in_valid;
    logic       s;
    logic       cout;
    logic       out_valid;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [1:0] exp_q[$];
    logic       hold_s;
    logic       hold_c;

    alu_1bit #(
        .OUT_REG(1'b1)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .op       (op),
        .in_valid (in_valid),
        .s        (s),
        .cout     (cout),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Arithmetic reference: {s, cout} from an integer sum rather than gate equations.
    function automatic logic [1:0] model(input logic [1:0] f_op, input logic fa, input logic fb,
                                         input logic fc);
        int unsigned sum;
        case (f_op)
            2'b00:   return {~(fa | fb), 1'b0};
            2'b01:   return {fa ^ fb, 1'b0};
            2'b10:   sum = int'(fa) + int'(fb) + int'(fc);
            default: sum = int'(fa) + (1 - int'(fb)) + int'(fc);
        endcase
        return {sum[0], sum[1]};
    endfunction

    // Called at posedge+1: drive one beat, wait an edge, then score the output.
    task automatic cycle(input string tag, input logic [1:0] t_op, input logic ta,
                         input logic tb, input logic tc, input logic tv);
        logic [1:0] e;
        op       = t_op;
        a        = ta;
        b        = tb;
        cin      = tc;
        in_valid = tv;
        if (tv) exp_q.push_back(model(t_op, ta, tb, tc));
        @(posedge clk);
        #1;
        check_bit({tag, "_valid"}, out_valid, tv);
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check_bit({tag, "_unexpected"}, 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check_bit({tag, "_s"}, s, e[1]);
                check_bit({tag, "_cout"}, cout, e[0]);
                hold_s = e[1];
                hold_c = e[0];
            end
        end else begin
            check_bit({tag, "_hold_s"}, s, hold_s);
            check_bit({tag, "_hold_cout"}, cout, hold_c);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b1;
        a        = 1'b0;
        b        = 1'b0;
        cin      = 1'b0;
        op       = 2'b00;
        in_valid = 1'b0;
        hold_s   = 1'b0;
        hold_c   = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_bit("rst_s", s, 1'b0);
        check_bit("rst_cout", cout, 1'b0);
        check_bit("rst_valid", out_valid, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_bit("post_rst_valid", out_valid, 1'b0);

        // XOR basics
        cycle("xor00", 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("xor10", 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);

        // NOR truth table, back-to-back
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            cycle("nor", 2'b00, ab[1], ab[0], 1'b1, 1'b1);
        end

        cycle("add111", 2'b10, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle("add100", 2'b10, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle("sub111", 2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle("sub011", 2'b11, 1'b0, 1'b1, 1'b1, 1'b1);

        // One valid beat then three idle beats with changing inputs
        cycle("cap", 2'b10, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle("idle1", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("idle2", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("idle3", 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);

        // Random mix of valid and idle beats
        for (int i = 0; i < 48; i++) begin
            cycle("rnd", 2'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                  1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        // Asynchronous reset between edges while s=1, out_valid=1
        cycle("pre_rst", 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
        check_bit("pre_rst_s_one", s, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("arst_s", s, 1'b0);
        check_bit("arst_cout", cout, 1'b0);
        check_bit("arst_valid", out_valid, 1'b0);
        op       = 2'b10;
        a        = 1'b1;
        b        = 1'b1;
        cin      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_bit("in_rst_s", s, 1'b0);
        check_bit("in_rst_cout", cout, 1'b0);
        check_bit("in_rst_valid", out_valid, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        hold_s   = 1'b0;
        hold_c   = 1'b0;
        @(posedge clk);
        #1;
        check_bit("rel_s", s, 1'b0);
        check_bit("rel_valid", out_valid, 1'b0);
        cycle("rel_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("rel_cap", 2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle("rel_cap2", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

        check_bit("queue_empty", 1'(exp_q.size() == 0), 1'b1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
